// File: rtl/display_frame_sequencer.sv
// rtl/display_frame_sequencer.sv - sequences power-up, init list and framebuffer pushes onto the SPI byte engine
module display_frame_sequencer #(
  parameter int POWERUP_CYCLES = 50_000,
  parameter int FRAME_BYTES    = 1024,
  parameter int ADDR_W         = 10,
  parameter int REFRESH_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_dc,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              init_done,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    PWRUP, INIT, IDLE, WINDOW, FETCH, CAPTURE, SEND, DONE
  } state_t;

  localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PW-1:0]     PWR_LAST = PW'(POWERUP_CYCLES - 1);
  localparam logic [PW-1:0]     PWR_ONE  = PW'(1);
  localparam logic [RW-1:0]     REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0]     REF_ONE  = RW'(1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [ADDR_W-1:0] PIX_ONE  = ADDR_W'(1);

  state_t            state;
  logic [PW-1:0]     pwr_cnt;
  logic [RW-1:0]     ref_cnt;
  logic [2:0]        byte_idx;
  logic [ADDR_W-1:0] pix_idx;
  logic              pending;

  logic accept;
  logic ref_wrap;
  logic req;
  logic take;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    init_byte = 8'hAE;
      3'd1:    init_byte = 8'h20;
      3'd2:    init_byte = 8'h00;
      3'd3:    init_byte = 8'h8D;
      3'd4:    init_byte = 8'h14;
      3'd5:    init_byte = 8'hA1;
      3'd6:    init_byte = 8'hC8;
      default: init_byte = 8'hAF;
    endcase
  endfunction

  function automatic logic [7:0] window_byte(input logic [2:0] i);
    case (i)
      3'd0:    window_byte = 8'h21;
      3'd1:    window_byte = 8'h00;
      3'd2:    window_byte = 8'h7F;
      3'd3:    window_byte = 8'h22;
      3'd4:    window_byte = 8'h00;
      3'd5:    window_byte = 8'h07;
      default: window_byte = 8'h00;
    endcase
  endfunction

  assign accept   = tx_valid && tx_ready;
  assign ref_wrap = init_done && (ref_cnt == REF_LAST);
  assign req      = init_done && (frame_req || ref_wrap);
  assign take     = (state == IDLE) && pending;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (init_done) begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_ONE;
    end
  end

  // A request landing in the same cycle the flag is consumed must survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (take) begin
      pending <= req;
    end else if (req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PWRUP;
      pwr_cnt    <= '0;
      byte_idx   <= '0;
      pix_idx    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      tx_dc      <= 1'b0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      fb_rd      <= 1'b0;
      case (state)
        PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            state    <= INIT;
            byte_idx <= 3'd0;
            tx_valid <= 1'b1;
            tx_dc    <= 1'b0;
            tx_data  <= init_byte(3'd0);
          end else begin
            pwr_cnt <= pwr_cnt + PWR_ONE;
          end
        end
        INIT: begin
          if (accept) begin
            if (byte_idx == 3'd7) begin
              tx_valid  <= 1'b0;
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= init_byte(byte_idx + 3'd1);
            end
          end
        end
        IDLE: begin
          if (pending) begin
            state    <= WINDOW;
            byte_idx <= 3'd0;
            tx_valid <= 1'b1;
            tx_dc    <= 1'b0;
            tx_data  <= window_byte(3'd0);
          end
        end
        WINDOW: begin
          if (accept) begin
            if (byte_idx == 3'd5) begin
              tx_valid <= 1'b0;
              pix_idx  <= '0;
              fb_rd    <= 1'b1;
              fb_addr  <= '0;
              state    <= FETCH;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= window_byte(byte_idx + 3'd1);
            end
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          tx_data  <= fb_data;
          tx_dc    <= 1'b1;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (accept) begin
            tx_valid <= 1'b0;
            if (pix_idx == PIX_LAST) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              pix_idx <= pix_idx + PIX_ONE;
              fb_rd   <= 1'b1;
              fb_addr <= pix_idx + PIX_ONE;
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// tb/tb_display_frame_sequencer.sv - directed bench for display_frame_sequencer
module tb_display_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       rst, frame_req_a, tx_ready_a;
  logic       tx_valid_a, tx_dc_a, fb_rd_a, init_done_a, busy_a, frame_done_a;
  logic [7:0] tx_data_a;
  logic [9:0] fb_addr_a;
  logic [7:0] fb_data_a = 8'h00;

  logic       rst_b, frame_req_b, tx_ready_b;
  logic       tx_valid_b, tx_dc_b, fb_rd_b, init_done_b, busy_b, frame_done_b;
  logic [7:0] tx_data_b;
  logic [9:0] fb_addr_b;
  logic [7:0] fb_data_b = 8'h00;

  logic [7:0] fb_mem [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] init_exp [0:7] = '{8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8, 8'hAF};
  logic [7:0] frame_exp [0:9] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
                                  8'h11, 8'h22, 8'h33, 8'h44};

  always @(posedge clk) if (fb_rd_a) fb_data_a <= fb_mem[fb_addr_a[1:0]];
  always @(posedge clk) if (fb_rd_b) fb_data_b <= fb_mem[fb_addr_b[1:0]];

  int fd_total = 0;
  always @(posedge clk) if (frame_done_a) fd_total <= fd_total + 1;

  display_frame_sequencer #(
    .POWERUP_CYCLES(4), .FRAME_BYTES(4), .ADDR_W(10), .REFRESH_CYCLES(1_000_000)
  ) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a), .tx_dc(tx_dc_a),
    .fb_rd(fb_rd_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
    .init_done(init_done_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  display_frame_sequencer #(
    .POWERUP_CYCLES(4), .FRAME_BYTES(4), .ADDR_W(10), .REFRESH_CYCLES(64)
  ) dut_refresh (
    .clk(clk), .rst(rst_b), .frame_req(frame_req_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b), .tx_dc(tx_dc_b),
    .fb_rd(fb_rd_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
    .init_done(init_done_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  task test_reset;
    rst = 1'b1; frame_req_a = 1'b0; tx_ready_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid_a, tx_data_a, tx_dc_a, fb_rd_a} !== 11'h000) begin
      failures++;
      $display("FAIL reset_tx got valid=%b data=%h dc=%b fb_rd=%b exp 0/00/0/0",
               tx_valid_a, tx_data_a, tx_dc_a, fb_rd_a);
    end
    checks++;
    if (fb_addr_a !== 10'd0) begin
      failures++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr_a);
    end
    checks++;
    if ({init_done_a, busy_a, frame_done_a} !== 3'b010) begin
      failures++;
      $display("FAIL reset_status got init_done=%b busy=%b frame_done=%b exp 0/1/0",
               init_done_a, busy_a, frame_done_a);
    end
    rst = 1'b0;
    frame_req_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid_a !== 1'b0) begin
        failures++; $display("FAIL pwrup_quiet cycle=%0d got tx_valid=%b exp=0", i, tx_valid_a);
      end
      @(negedge clk);
      frame_req_a = 1'b0;
    end
  endtask

  task test_init_backpressure;
    int b;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid_a !== 1'b1 || tx_data_a !== init_exp[i] || tx_dc_a !== 1'b0) begin
        failures++;
        $display("FAIL init_byte%0d got valid=%b data=%h dc=%b exp 1/%h/0",
                 i, tx_valid_a, tx_data_a, tx_dc_a, init_exp[i]);
      end
      if (i == 3) begin
        tx_ready_a = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          checks++;
          if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h8D) begin
            failures++;
            $display("FAIL backpressure_hold%0d got valid=%b data=%h exp 1/8d", h, tx_valid_a, tx_data_a);
          end
        end
        tx_ready_a = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if ({init_done_a, busy_a, tx_valid_a} !== 3'b100) begin
      failures++;
      $display("FAIL init_complete got init_done=%b busy=%b tx_valid=%b exp 1/0/0",
               init_done_a, busy_a, tx_valid_a);
    end
    b = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_a) b++;
    end
    checks++;
    if (b != 0) begin
      failures++; $display("FAIL early_req_dropped got busy_cycles=%0d exp=0", b);
    end
  endtask

  task test_frame;
    int n, fd, c0, c1;
    n = 0; fd = 0; c0 = -1; c1 = -1;
    frame_req_a = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx_valid_a && n < 10) begin
        checks++;
        if (tx_data_a !== frame_exp[n] || tx_dc_a !== (n >= 6)) begin
          failures++;
          $display("FAIL frame_byte%0d got data=%h dc=%b exp %h/%b",
                   n, tx_data_a, tx_dc_a, frame_exp[n], (n >= 6));
        end
        if (n >= 6) begin
          checks++;
          if (fb_addr_a !== 10'(n - 6)) begin
            failures++; $display("FAIL frame_fb_addr%0d got=%0d exp=%0d", n, fb_addr_a, n - 6);
          end
        end
        if (n == 0) c0 = cyc;
        n++;
      end
      if (frame_done_a) begin
        fd++; c1 = cyc;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 10) begin
      failures++; $display("FAIL frame_byte_count got=%0d exp=10", n);
    end
    checks++;
    if (fd != 1) begin
      failures++; $display("FAIL frame_done_pulses got=%0d exp=1", fd);
    end
    checks++;
    if (c1 - c0 + 1 != 19) begin
      failures++; $display("FAIL frame_length got=%0d exp=19", c1 - c0 + 1);
    end
  endtask

  task test_merged;
    int f0;
    f0 = fd_total;
    frame_req_a = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    repeat (4) @(negedge clk);
    repeat (3) begin
      frame_req_a = 1'b1;
      @(negedge clk);
      frame_req_a = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (fd_total - f0 != 2) begin
      failures++; $display("FAIL merged_frames got=%0d exp=2", fd_total - f0);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL merged_idle got busy=%b exp=0", busy_a);
    end
  endtask

  task test_back_to_back;
    int f0, k;
    f0 = fd_total;
    frame_req_a = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    k = 0;
    while (frame_done_a !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (frame_done_a !== 1'b1) begin
      failures++; $display("FAIL b2b_wait_done got frame_done=%b exp=1 (timeout)", frame_done_a);
    end
    frame_req_a = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL b2b_idle_gap got busy=%b exp=0", busy_a);
    end
    @(negedge clk);
    checks++;
    if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h21 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart got valid=%b data=%h busy=%b exp 1/21/1", tx_valid_a, tx_data_a, busy_a);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (fd_total - f0 != 2) begin
      failures++; $display("FAIL b2b_frames got=%0d exp=2", fd_total - f0);
    end
  endtask

  task test_reset_mid_frame;
    int k;
    frame_req_a = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    k = 0;
    while (!(tx_valid_a === 1'b1 && tx_dc_a === 1'b1 && tx_data_a === 8'h22) && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_data_a !== 8'h22 || tx_dc_a !== 1'b1) begin
      failures++; $display("FAIL midreset_wait_pixel2 got data=%h dc=%b exp 22/1 (timeout)", tx_data_a, tx_dc_a);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_valid_a, init_done_a, busy_a} !== 3'b001) begin
      failures++;
      $display("FAIL midreset_state got valid=%b init_done=%b busy=%b exp 0/0/1",
               tx_valid_a, init_done_a, busy_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid_a !== 1'b0) begin
        failures++; $display("FAIL midreset_pwrup cycle=%0d got tx_valid=%b exp=0", i, tx_valid_a);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid_a !== 1'b1 || tx_data_a !== init_exp[i] || tx_dc_a !== 1'b0) begin
        failures++;
        $display("FAIL midreset_init%0d got valid=%b data=%h dc=%b exp 1/%h/0",
                 i, tx_valid_a, tx_data_a, tx_dc_a, init_exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (init_done_a !== 1'b1) begin
      failures++; $display("FAIL midreset_init_done got=%b exp=1", init_done_a);
    end
  endtask

  task test_refresh;
    int i0, k;
    int starts[$];
    logic prev;
    frame_req_b = 1'b0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    k = 0;
    while (init_done_b !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (init_done_b !== 1'b1) begin
      failures++; $display("FAIL refresh_init got init_done=%b exp=1 (timeout)", init_done_b);
    end
    i0 = cyc;
    prev = busy_b;
    while (cyc < i0 + 240) begin
      frame_req_b = (cyc == i0 + 127);
      @(negedge clk);
      if (busy_b && !prev) starts.push_back(cyc - i0);
      prev = busy_b;
    end
    frame_req_b = 1'b0;
    checks++;
    if (starts.size() != 3) begin
      failures++; $display("FAIL refresh_frame_count got=%0d exp=3", starts.size());
    end else begin
      checks++;
      if (starts[0] != 65) begin
        failures++; $display("FAIL refresh_first_start got=%0d exp=65", starts[0]);
      end
      checks++;
      if (starts[1] != 129) begin
        failures++; $display("FAIL refresh_merged_start got=%0d exp=129", starts[1]);
      end
      checks++;
      if (starts[2] != 193) begin
        failures++; $display("FAIL refresh_third_start got=%0d exp=193", starts[2]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_req_a = 1'b0; tx_ready_a = 1'b1;
    rst_b = 1'b1; frame_req_b = 1'b0; tx_ready_b = 1'b1;
    test_reset;
    test_init_backpressure;
    test_frame;
    test_merged;
    test_back_to_back;
    test_reset_mid_frame;
    test_refresh;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_frame_sequencer.md
# display_frame_sequencer

Controller that sequences the shared SPI byte transmitter of the Tamaguchi display path. After reset it waits out the panel power-up delay, streams a fixed 8-byte init command list, and then pushes full frames. Each frame is a 6-byte address-window command header followed by FRAME_BYTES pixel bytes read from the framebuffer. Frames are triggered by an external request or by an internal refresh timer. It sits between the framebuffer RAM and the byte-level SPI engine that drives spi_mosi/spi_sck/spi_cs/spi_dc.

## Interface
- POWERUP_CYCLES, 50_000: idle cycles after reset before the first init byte (1 ms at 50 MHz).
- FRAME_BYTES, 1024: pixel bytes per frame (128x64 monochrome). Must be ≥1 and ≤2^ADDR_W.
- ADDR_W, 10: framebuffer address width.
- REFRESH_CYCLES, 2_500_000: auto-refresh period in clk cycles (20 Hz).

- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- frame_req  in  1  one-cycle pulse requesting a frame push
- tx_valid  out  1  byte offered to the SPI engine
- tx_ready  in  1  SPI engine can accept a byte
- tx_data  out  8  byte to shift out
- tx_dc  out  1  0 = command, 1 = pixel data (drives spi_dc)
- fb_rd  out  1  framebuffer read strobe
- fb_addr  out  ADDR_W  framebuffer read address
- fb_data  in  8  read data, valid exactly 1 cycle after fb_rd
- init_done  out  1  high once the init list is fully accepted; stays high until rst
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel byte is accepted

## Operation
- States: PWRUP, INIT, IDLE, WINDOW, FETCH, CAPTURE, SEND, DONE.
- A byte transfers on a rising edge with tx_valid && tx_ready.
  - tx_data and tx_dc hold stable while tx_valid is high and not accepted.
  - tx_valid never drops before acceptance except on rst.
- PWRUP: counts POWERUP_CYCLES cycles with tx_valid=0, then goes to INIT.
- INIT: sends, with tx_dc=0: 0xAE, 0x20, 0x00, 0x8D, 0x14, 0xA1, 0xC8, 0xAF.
  - Back-to-back: the next byte is valid in the cycle after acceptance.
  - After the 8th byte is accepted, init_done is set and the state goes to IDLE.
- IDLE: if pending is set, clear it and go to WINDOW.
- WINDOW: sends, with tx_dc=0: 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07. Then goes to FETCH with the pixel index at 0.
- FETCH: drives fb_rd=1 and fb_addr=index for one cycle, then CAPTURE.
- CAPTURE: latches fb_data into tx_data with tx_dc=1, asserts tx_valid, then SEND.
- SEND: waits for acceptance.
  - If index == FRAME_BYTES-1, go to DONE.
  - Otherwise increment index and go to FETCH.
- DONE: pulses frame_done for one cycle, then IDLE.
- Pending request flag (one deep):
  - Set by frame_req or by refresh timer expiry while init_done=1.
  - Requests arriving while pending is already set are merged into it.
  - A request arriving during a frame is served right after that frame's DONE.
  - frame_req before init_done is dropped.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 continuously once init_done=1; expiry sets pending on the wrap.
  - Not restarted by frame_req.
- fb_addr holds its last value when fb_rd=0.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, tx_dc=0, fb_rd=0, fb_addr=0, init_done=0, busy=1, frame_done=0. Pending and the refresh counter are cleared.
- rst mid-frame or mid-init:
  - On the next edge the state is PWRUP and tx_valid=0.
  - The SPI engine shares rst, so no partial byte survives.
- First init byte: tx_valid rises on the cycle after PWRUP reaches POWERUP_CYCLES-1.
- Frame start latency: IDLE with pending → first WINDOW byte valid on the next cycle.
- Pixel byte cadence with tx_ready held high is 3 cycles per byte: FETCH, CAPTURE, SEND-accept.
- Minimum frame length is 6 + 3·FRAME_BYTES + 1 cycles from WINDOW entry to the frame_done cycle.
- Simultaneous frame_req and timer expiry in the same cycle produce a single pending request.
- frame_req in the same cycle as DONE: the next frame is served (IDLE→WINDOW) with no gap beyond one IDLE cycle.

## Test plan
- Reset/power-up (POWERUP_CYCLES=4): release rst → tx_valid=0 for 4 cycles, then the 8 init bytes in order with tx_dc=0, tx_ready=1 → back-to-back transfers, then init_done=1 and busy=0.
- Backpressure: hold tx_ready=0 for 5 cycles on init byte 0x8D → tx_data=0x8D and tx_valid=1 stable throughout; the next byte is 0x14 after release.
- Frame push (FRAME_BYTES=4, framebuffer 0x11,0x22,0x33,0x44): frame_req pulse → 21 00 7F 22 00 07 with dc=0, then 11 22 33 44 with dc=1, fb_addr 0..3, one frame_done pulse, 19 cycles from WINDOW entry.
- Merged requests: 3 frame_req pulses during one frame → exactly one extra frame follows; frame_req before init_done → no frame.
- Auto-refresh (REFRESH_CYCLES=64, no frame_req): frames start at a 64-cycle spacing after init_done; a simultaneous frame_req and timer expiry yield one frame.
- Reset mid-frame: assert rst during pixel byte 2 → next edge tx_valid=0 and init_done=0, and the full power-up/init sequence repeats.
